// File: rtl/interface_hcsr04_uc.sv
// -----------------------------------------------------------------------------
// interface_hcsr04_uc
// Control unit for one HC-SR04 ultrasonic measurement per request.
// Sequence: clear the cm counter, emit a TRIGGER_CYCLES-wide trigger pulse,
// synchronize the sensor echo and forward it as `pulso`, wait for the cm
// counter's `cm_pronto`, then latch its 3-digit BCD result into `medida`.
// An echo-timeout timer bounds the ESPERA_ECHO + MEDIDA window.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   medir      in   level request to start a measurement
//   echo       in   raw (asynchronous) sensor echo
//   cm_pronto  in   done flag from the cm counter
//   cm_bcd     in   BCD distance from the cm counter {hundreds, tens, units}
//   trigger    out  sensor trigger pulse
//   pulso      out  synchronized echo, feeds the cm counter
//   zera_cm    out  one-clock clear request to the cm counter
//   medida     out  last valid BCD distance
//   pronto     out  measurement complete (held until the next request)
//   timeout    out  one-clock echo-timeout flag
//   db_estado  out  current state code, for debug
// -----------------------------------------------------------------------------
module interface_hcsr04_uc #(
  parameter int TRIGGER_CYCLES = 500,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  input  logic        cm_pronto,
  input  logic [11:0] cm_bcd,
  output logic        trigger,
  output logic        pulso,
  output logic        zera_cm,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        timeout,
  output logic [3:0]  db_estado
);

  // A parameter of 1 would give a zero-width counter; keep at least one bit.
  localparam int TRIG_W = (TRIGGER_CYCLES > 1) ? $clog2(TRIGGER_CYCLES) : 1;
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIGGER_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_INICIAL       = 4'd0,
    ST_PREPARACAO    = 4'd1,
    ST_ENVIA_TRIGGER = 4'd2,
    ST_ESPERA_ECHO   = 4'd3,
    ST_MEDIDA        = 4'd4,
    ST_ESPERA_CM     = 4'd5,
    ST_ARMAZENA      = 4'd6,
    ST_FINAL         = 4'd7,
    ST_TIMEOUT       = 4'd8
  } estado_e;

  estado_e           estado_q, estado_d;
  logic [TRIG_W-1:0] trig_cnt_q, trig_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [11:0]       medida_q, medida_d;
  logic              echo_meta_q;
  logic              pulso_q;

  // ---------------------------------------------------------------------------
  // State, timers, result register and the two-flop echo synchronizer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values;
    // the synchronizer chain below depends on it to stay two flops deep.
    if (reset) begin
      estado_q    <= ST_INICIAL;
      trig_cnt_q  <= '0;
      to_cnt_q    <= '0;
      medida_q    <= 12'h000;
      echo_meta_q <= 1'b0;
      pulso_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      trig_cnt_q  <= trig_cnt_d;
      to_cnt_q    <= to_cnt_d;
      medida_q    <= medida_d;
      echo_meta_q <= echo;
      pulso_q     <= echo_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path can leave one
    // unassigned, which would otherwise infer a latch.
    estado_d   = estado_q;
    trig_cnt_d = trig_cnt_q;
    to_cnt_d   = to_cnt_q;
    medida_d   = medida_q;

    unique case (estado_q)
      ST_INICIAL: begin
        if (medir) estado_d = ST_PREPARACAO;
      end

      ST_PREPARACAO: begin
        trig_cnt_d = '0;
        to_cnt_d   = '0;
        estado_d   = ST_ENVIA_TRIGGER;
      end

      ST_ENVIA_TRIGGER: begin
        trig_cnt_d = trig_cnt_q + 1'b1;
        if (trig_cnt_q == TRIG_LAST) estado_d = ST_ESPERA_ECHO;
      end

      // The timeout window spans ESPERA_ECHO and MEDIDA together, so to_cnt
      // keeps counting across the transition between them.
      ST_ESPERA_ECHO: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (pulso_q)                  estado_d = ST_MEDIDA;
        else if (to_cnt_q == TO_LAST) estado_d = ST_TIMEOUT;
      end

      // An echo fall on the same clock as the last timeout count wins.
      ST_MEDIDA: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (!pulso_q)                 estado_d = ST_ESPERA_CM;
        else if (to_cnt_q == TO_LAST) estado_d = ST_TIMEOUT;
      end

      ST_ESPERA_CM: begin
        if (cm_pronto) estado_d = ST_ARMAZENA;
      end

      ST_ARMAZENA: begin
        medida_d = cm_bcd;
        estado_d = ST_FINAL;
      end

      ST_FINAL: begin
        if (medir) estado_d = ST_PREPARACAO;
      end

      ST_TIMEOUT: begin
        estado_d = ST_INICIAL;
      end

      default: begin
        estado_d = ST_INICIAL;
      end
    endcase
  end

  // Moore decodes of the state register; pulso and medida come from flops.
  assign trigger   = (estado_q == ST_ENVIA_TRIGGER);
  assign zera_cm   = (estado_q == ST_PREPARACAO);
  assign pronto    = (estado_q == ST_FINAL);
  assign timeout   = (estado_q == ST_TIMEOUT);
  assign db_estado = estado_q;
  assign pulso     = pulso_q;
  assign medida    = medida_q;

endmodule

// File: tb/tb_interface_hcsr04_uc.sv
// -----------------------------------------------------------------------------
// tb_interface_hcsr04_uc
// Scoreboard bench for interface_hcsr04_uc with short timers. Each issued
// measurement pushes its expected outcome (completed or timed out, and the
// resulting medida) into a queue; a monitor pops and compares whenever the
// DUT raises pronto or timeout. The bench also acts as the cm counter.
// -----------------------------------------------------------------------------
module tb_interface_hcsr04_uc;

  localparam int TRIG = 5;
  localparam int TO   = 100;

  logic        clock;
  logic        reset;
  logic        medir;
  logic        echo;
  logic        cm_pronto;
  logic [11:0] cm_bcd;
  logic        trigger;
  logic        pulso;
  logic        zera_cm;
  logic [11:0] medida;
  logic        pronto;
  logic        timeout;
  logic [3:0]  db_estado;

  interface_hcsr04_uc #(
    .TRIGGER_CYCLES(TRIG),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .medir    (medir),
    .echo     (echo),
    .cm_pronto(cm_pronto),
    .cm_bcd   (cm_bcd),
    .trigger  (trigger),
    .pulso    (pulso),
    .zera_cm  (zera_cm),
    .medida   (medida),
    .pronto   (pronto),
    .timeout  (timeout),
    .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        timed_out;
    logic [11:0] med;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          trig_pulses = 0;
  logic [11:0] model_medida = 12'h000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts trigger pulses, measures the timeout window and pops the
  // scoreboard on every completion or timeout event.
  initial begin
    logic trig_prev;
    logic pronto_prev;
    int   win;
    exp_t e;
    trig_prev   = 1'b0;
    pronto_prev = 1'b0;
    win         = 0;
    forever begin
      @(negedge clock);
      if (trigger && !trig_prev) trig_pulses++;
      trig_prev = trigger;

      if ((pronto && !pronto_prev) || timeout) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: pronto=%0b timeout=%0b with nothing expected (t=%0t)",
                   pronto, timeout, $time);
        end else begin
          e = sb_q.pop_front();
          check("sb_timeout_kind", 32'(timeout), 32'(e.timed_out));
          check("sb_medida", 32'(medida), 32'(e.med));
          if (timeout) check("sb_pronto_low_on_timeout", 32'(pronto), 32'd0);
        end
      end
      pronto_prev = pronto;

      // The window is the number of clocks spent in ESPERA_ECHO + MEDIDA.
      if (db_estado == 4'd3 || db_estado == 4'd4) begin
        win++;
      end else begin
        if (db_estado == 4'd8) check("timeout_window", 32'(win), 32'(TO));
        win = 0;
      end
    end
  end

  // One measurement. Echo timing is expressed in clocks after the trigger
  // falls: echo rises at `rise` and drops at `fall` (pre=1: echo is already
  // high before the trigger ends). pulso lags echo by 2 clocks and the FSM
  // reacts one clock later, so the fall is seen fall+3 clocks after entering
  // ESPERA_ECHO; a fall seen on the last window clock still counts.
  task automatic run_meas(input int rise, input int fall, input bit has_echo,
                          input bit pre, input bit hold, input logic [11:0] bcd,
                          input int cmdly);
    bit   timed_out;
    exp_t e;
    int   cnt;
    int   trig_before;

    timed_out = !has_echo || (fall + 3 > TO);
    if (!timed_out) model_medida = bcd;
    e.timed_out = timed_out;
    e.med       = model_medida;
    sb_q.push_back(e);
    trig_before = trig_pulses;

    cm_pronto = 1'b0;
    cm_bcd    = bcd;
    medir     = 1'b1;
    @(negedge clock);
    check("zera_cm_on", 32'(zera_cm), 32'd1);
    check("state_preparacao", 32'(db_estado), 32'd1);
    check("pronto_drops_on_request", 32'(pronto), 32'd0);
    if (!hold) medir = 1'b0;
    @(negedge clock);
    check("zera_cm_one_clock", 32'(zera_cm), 32'd0);

    cnt = 0;
    while (trigger && cnt < 50) begin
      cnt++;
      if (pre && cnt == 2) echo = 1'b1;
      @(negedge clock);
    end
    check("trigger_width", 32'(cnt), 32'(TRIG));

    if (has_echo) begin
      for (int idx = 0; idx <= fall; idx++) begin
        if (pre && idx == 1) check("echo_high_at_entry", 32'(db_estado), 32'd4);
        if (!pre && idx == rise) echo = 1'b1;
        if (idx == fall) echo = 1'b0;
        else @(negedge clock);
      end
    end
    medir = 1'b0;

    if (!timed_out) begin
      repeat (cmdly) @(negedge clock);
      cm_pronto = 1'b1;
      cnt = 0;
      while (!pronto && cnt < 300) begin
        cnt++;
        @(negedge clock);
      end
      check("pronto_reached", 32'(pronto), 32'd1);
      check("state_final", 32'(db_estado), 32'd7);
    end else begin
      cnt = 0;
      while (db_estado != 4'd0 && cnt < 300) begin
        cnt++;
        @(negedge clock);
      end
      check("back_to_inicial", 32'(db_estado), 32'd0);
      check("pronto_low_after_timeout", 32'(pronto), 32'd0);
      check("medida_kept", 32'(medida), 32'(model_medida));
    end
    repeat (2) @(negedge clock);
    check("single_trigger_pulse", 32'(trig_pulses - trig_before), 32'd1);
  endtask

  task automatic reset_mid_trigger();
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    repeat (3) @(negedge clock);
    check("trigger_before_reset", 32'(trigger), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    model_medida = 12'h000;
    check("rst_trigger", 32'(trigger), 32'd0);
    check("rst_state", 32'(db_estado), 32'd0);
    check("rst_medida", 32'(medida), 32'h000);
    check("rst_pronto", 32'(pronto), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] rbcd;
    int          r_rise;
    int          r_fall;
    bit          r_echo;

    reset     = 1'b1;
    medir     = 1'b0;
    echo      = 1'b1;
    cm_pronto = 1'b0;
    cm_bcd    = 12'h000;
    repeat (2) @(negedge clock);
    check("reset_state", 32'(db_estado), 32'd0);
    check("reset_trigger", 32'(trigger), 32'd0);
    check("reset_pulso", 32'(pulso), 32'd0);
    check("reset_zera_cm", 32'(zera_cm), 32'd0);
    check("reset_pronto", 32'(pronto), 32'd0);
    check("reset_timeout", 32'(timeout), 32'd0);
    check("reset_medida", 32'(medida), 32'h000);
    echo  = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clock);

    run_meas(10, 30, 1'b1, 1'b0, 1'b0, 12'h123, 3);   // basic measurement
    run_meas(0, 0, 1'b0, 1'b0, 1'b0, 12'h999, 0);     // no echo at all
    run_meas(5, 150, 1'b1, 1'b0, 1'b0, 12'h999, 2);   // echo stuck high
    run_meas(8, 40, 1'b1, 1'b0, 1'b1, 12'h456, 1);    // medir held high
    run_meas(12, 25, 1'b1, 1'b0, 1'b0, 12'h045, 3);   // back-to-back from FINAL
    run_meas(10, 97, 1'b1, 1'b0, 1'b0, 12'h777, 1);   // fall on last window clock
    run_meas(10, 98, 1'b1, 1'b0, 1'b0, 12'h888, 1);   // fall one clock too late
    reset_mid_trigger();
    run_meas(6, 20, 1'b1, 1'b0, 1'b0, 12'h321, 2);    // full restart after reset
    run_meas(0, 15, 1'b1, 1'b1, 1'b0, 12'h654, 2);    // echo high at entry

    for (int n = 0; n < 10; n++) begin
      rbcd   = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      r_rise = $urandom_range(0, 40);
      r_fall = r_rise + $urandom_range(1, 70);
      r_echo = ($urandom_range(0, 5) != 0);
      run_meas(r_rise, r_fall, r_echo, 1'b0, 1'b0, rbcd, $urandom_range(0, 5));
    end

    repeat (5) @(negedge clock);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/interface_hcsr04_uc.md
Name: interface_hcsr04_uc

Overview:
- Control unit that runs one HC-SR04 ultrasonic measurement cycle per request.
- Sequence per measurement: generate the trigger pulse, synchronize the echo, forward it as `pulso` to the cm counter, wait for the counter's `pronto`, latch the 3-digit BCD distance.
- Sits directly upstream of the cm counter and feeds its `pulso` input. Also clears that counter before each measurement.
- Includes its own trigger-width timer and echo-timeout timer.

Parameters:
- TRIGGER_CYCLES, 500, trigger high time in clocks (10 us at 50 MHz).
- TIMEOUT_CYCLES, 2000000, maximum clocks allowed in ESPERA_ECHO + MEDIDA combined (40 ms at 50 MHz).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- medir  in  1  level request to start a measurement.
- echo  in  1  raw sensor echo (asynchronous).
- cm_pronto  in  1  done flag from the cm counter.
- cm_bcd  in  12  BCD distance from the cm counter (hundreds [11:8], tens [7:4], units [3:0]).
- trigger  out  1  sensor trigger pulse.
- pulso  out  1  synchronized echo, to the cm counter `pulso` input.
- zera_cm  out  1  clear request to the cm counter.
- medida  out  12  last valid BCD distance.
- pronto  out  1  measurement complete.
- timeout  out  1  echo-timeout flag.
- db_estado  out  4  current state code, for debug.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- State after reset: INICIAL; medida=0x000.
- Output values after reset: trigger=0, pulso=0, zera_cm=0, pronto=0, timeout=0.
- Echo synchronizer:
  - Two-flop synchronizer on `echo`; the second flop is `pulso`.
  - A change on `echo` appears on `pulso` 2 clocks later.
  - Both flops clear on reset.
- Timers: two internal counters.
  - trig_cnt counts only in ENVIA_TRIGGER.
  - to_cnt counts in ESPERA_ECHO and MEDIDA.
  - Both clear in PREPARACAO.
  - Both are sized by $clog2 of their parameter.
- State codes (db_estado):
  - INICIAL=0, PREPARACAO=1, ENVIA_TRIGGER=2, ESPERA_ECHO=3
  - MEDIDA=4, ESPERA_CM=5, ARMAZENA=6, FINAL=7, TIMEOUT=8
- Transitions (all registered, evaluated each rising edge):
  - INICIAL: medir=1 -> PREPARACAO; else stay.
  - PREPARACAO: always -> ENVIA_TRIGGER. Outputs zera_cm=1 for exactly 1 clock.
  - ENVIA_TRIGGER:
    - trigger=1 throughout.
    - Exit to ESPERA_ECHO when trig_cnt reaches TRIGGER_CYCLES-1.
    - trigger is therefore high for exactly TRIGGER_CYCLES clocks.
  - ESPERA_ECHO:
    - pulso=1 -> MEDIDA.
    - Otherwise, to_cnt reaching TIMEOUT_CYCLES-1 -> TIMEOUT.
    - If pulso is already high on entry, the transition happens on the first clock.
  - MEDIDA:
    - pulso=0 -> ESPERA_CM.
    - Otherwise, to_cnt reaching TIMEOUT_CYCLES-1 -> TIMEOUT.
    - If echo falls and the timeout is reached on the same clock, the echo fall wins.
  - ESPERA_CM: cm_pronto=1 -> ARMAZENA. No timeout in this state.
  - ARMAZENA: medida <= cm_bcd; -> FINAL.
  - FINAL:
    - pronto=1.
    - medir=1 -> PREPARACAO, i.e. back-to-back measurement; pronto drops on that same edge.
    - Otherwise stay; pronto holds until the next request.
  - TIMEOUT:
    - timeout=1 for exactly 1 clock; medida unchanged; -> INICIAL.
  - Unused codes 9..15 -> INICIAL.
- Output rules:
  - All outputs except pulso and medida are Moore decodes of the state register.
  - Measurement latency from trigger fall: 2 + echo_width + cm_pronto delay + 2 clocks until pronto=1.
- Request handling: medir is ignored in every state except INICIAL and FINAL. No queuing.
- Reset mid-operation: on the next edge, return to INICIAL.
  - trigger drops immediately at that edge; medida clears to 0x000; synchronizer and timers clear.
- Simultaneous events: reset overrides everything.

Test Plan (TRIGGER_CYCLES=5, TIMEOUT_CYCLES=100):
- Basic measurement: reset 2 clocks, then medir pulse 1 clock.
  - zera_cm high for 1 clock, then trigger high exactly 5 clocks.
  - Echo high 20 clocks starting 10 clocks later; cm_pronto=1 with cm_bcd=0x123 3 clocks after echo falls.
  - Required: medida=0x123, pronto=1, db_estado=7, timeout never set.
- Echo-start timeout: no echo after trigger.
  - Required: exactly 100 clocks in ESPERA_ECHO, then timeout=1 for 1 clock, state INICIAL, medida keeps its previous value (0x123), pronto=0.
- Echo-end timeout: echo held high indefinitely.
  - Required: TIMEOUT reached after 100 clocks counted across ESPERA_ECHO+MEDIDA; cm_bcd not latched.
- Request filtering and back-to-back runs:
  - medir held high during ENVIA_TRIGGER and MEDIDA -> no restart, exactly one trigger pulse.
  - medir=1 while in FINAL -> new measurement with cm_bcd=0x045 -> medida=0x045.
- Reset mid-trigger: reset asserted on the 3rd trigger clock.
  - Required: next edge gives trigger=0, db_estado=0, medida=0x000, pronto=0.
  - A following medir restarts a full 5-clock trigger.
- Echo high at entry: echo already high before ENVIA_TRIGGER ends.
  - Required: ESPERA_ECHO -> MEDIDA on the first clock.
  - pulso tracks echo with a 2-clock delay; measurement completes normally.
